// File: rtl/vga_fb_scan_controller.sv
// VGA scan controller with configurable timing, scaled framebuffer
// addressing and read-latency compensation. Counter state is stage 0,
// the address register is stage 1, outputs leave at stage READ_LATENCY+2.
module vga_fb_scan_controller #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned SYNC_POL     = 0,
  parameter int unsigned SCALE_SHIFT  = 2,
  parameter int unsigned BASE_ADDR    = 1000,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned COLOR_W      = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] ColorIn,
  output logic [ADDR_W-1:0]  Address,
  output logic               Hsync,
  output logic               Vsync,
  output logic               Active,
  output logic               FrameStart,
  output logic [COLOR_W-1:0] ColorOut
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  // Flag stages before the output register; the last one lines up with ColorIn.
  localparam int unsigned PIPE_N  = READ_LATENCY + 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [ADDR_W-1:0] BASE_C      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic              SYNC_LVL    = 1'(SYNC_POL);
  localparam logic              SYNC_IDLE   = ~SYNC_LVL;

  // Elaboration-time parameter sanity checks
  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("H_ACTIVE must be divisible by 2**SCALE_SHIFT");
  end
  if (READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 0..4");
  end

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic fs;
  } flags_t;

  logic [H_W-1:0]    h_cnt;
  logic [V_W-1:0]    v_cnt;
  flags_t            flags_c;
  logic [ADDR_W-1:0] row_c;
  logic [ADDR_W-1:0] col_c;
  logic [ADDR_W-1:0] addr_c;
  flags_t            flag_pipe [PIPE_N];

  // Horizontal/vertical position counters; line and frame wrap together
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Stage-0 flags and scaled linear address for the current counter state
  always_comb begin
    flags_c     = '0;
    flags_c.vis = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    flags_c.hs  = (h_cnt >= HS_START) && (h_cnt <= HS_END);
    flags_c.vs  = (v_cnt >= VS_START) && (v_cnt <= VS_END);
    flags_c.fs  = (h_cnt == '0) && (v_cnt == '0);
    row_c       = ADDR_W'(v_cnt >> SCALE_SHIFT);
    col_c       = ADDR_W'(h_cnt >> SCALE_SHIFT);
    addr_c      = BASE_C + row_c * LINE_STRIDE + col_c;
  end

  // Address register: base address outside the visible region
  always_ff @(posedge clk) begin
    if (reset) begin
      Address <= BASE_C;
    end else begin
      Address <= flags_c.vis ? addr_c : BASE_C;
    end
  end

  // Flag delay line matching the address register plus framebuffer latency
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(PIPE_N); i++) begin
        flag_pipe[i] <= '0;
      end
    end else begin
      for (int i = int'(PIPE_N) - 1; i > 0; i--) begin
        flag_pipe[i] <= flag_pipe[i-1];
      end
      flag_pipe[0] <= flags_c;
    end
  end

  // Output register: colour captured while ColorIn belongs to the delayed pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      Hsync      <= SYNC_IDLE;
      Vsync      <= SYNC_IDLE;
      Active     <= 1'b0;
      FrameStart <= 1'b0;
      ColorOut   <= '0;
    end else begin
      Hsync      <= flag_pipe[PIPE_N-1].hs ? SYNC_LVL : SYNC_IDLE;
      Vsync      <= flag_pipe[PIPE_N-1].vs ? SYNC_LVL : SYNC_IDLE;
      Active     <= flag_pipe[PIPE_N-1].vis;
      FrameStart <= flag_pipe[PIPE_N-1].fs;
      ColorOut   <= flag_pipe[PIPE_N-1].vis ? ColorIn : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_scan_controller.sv
// Directed bench for vga_fb_scan_controller on a small 14x7 timing.
module tb_vga_fb_scan_controller;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [14:0] lat_addr  [0:4];
  logic [15:0] lat_color [0:4];
  logic        lat_hs    [0:4];
  logic        lat_vs    [0:4];
  logic        lat_act   [0:4];
  logic        lat_fs    [0:4];

  // One instance per read latency; ColorIn is the address delayed L clocks
  for (genvar g = 0; g < 5; g++) begin : g_lat
    logic [14:0] addr;
    logic [15:0] cin;
    logic [15:0] cout;
    logic        hs, vs, act, fs;
    logic [14:0] dl [0:3];

    always @(posedge clk) begin
      dl[0] <= addr;
      for (int k = 1; k < 4; k++) dl[k] <= dl[k-1];
    end

    if (g == 0) begin : g_l0
      assign cin = {1'b0, addr};
    end else begin : g_ln
      assign cin = {1'b0, dl[g-1]};
    end

    vga_fb_scan_controller #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(0), .SCALE_SHIFT(1), .BASE_ADDR(100),
      .ADDR_W(15), .COLOR_W(16), .READ_LATENCY(g)
    ) u_dut (
      .clk(clk), .reset(reset), .ColorIn(cin), .Address(addr),
      .Hsync(hs), .Vsync(vs), .Active(act), .FrameStart(fs), .ColorOut(cout)
    );

    assign lat_addr[g]  = addr;
    assign lat_color[g] = cout;
    assign lat_hs[g]    = hs;
    assign lat_vs[g]    = vs;
    assign lat_act[g]   = act;
    assign lat_fs[g]    = fs;
  end

  // Positive-polarity sync instance
  logic [14:0] p_addr;
  logic [15:0] p_color;
  logic        p_hs, p_vs, p_act, p_fs;

  vga_fb_scan_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .SCALE_SHIFT(1), .BASE_ADDR(100),
    .ADDR_W(15), .COLOR_W(16), .READ_LATENCY(1)
  ) u_pol (
    .clk(clk), .reset(reset), .ColorIn(16'h1234), .Address(p_addr),
    .Hsync(p_hs), .Vsync(p_vs), .Active(p_act), .FrameStart(p_fs), .ColorOut(p_color)
  );

  // Narrow address instance that wraps modulo 256
  logic [7:0]  w_addr;
  logic [15:0] w_color;
  logic        w_hs, w_vs, w_act, w_fs;

  vga_fb_scan_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0), .SCALE_SHIFT(0), .BASE_ADDR(250),
    .ADDR_W(8), .COLOR_W(16), .READ_LATENCY(1)
  ) u_wrap (
    .clk(clk), .reset(reset), .ColorIn(16'hABCD), .Address(w_addr),
    .Hsync(w_hs), .Vsync(w_vs), .Active(w_act), .FrameStart(w_fs), .ColorOut(w_color)
  );

  // Reference model of the small timing, indexed by linear counter position t
  function automatic bit m_vis(input int t);
    return ((t % HT) < 8) && (((t / HT) % VT) < 4);
  endfunction
  function automatic bit m_hs(input int t);
    return ((t % HT) >= 10) && ((t % HT) <= 12);
  endfunction
  function automatic bit m_vs(input int t);
    return ((t / HT) % VT) == 5;
  endfunction
  function automatic bit m_fs(input int t);
    return (t % FRAME) == 0;
  endfunction
  function automatic int m_addr(input int t);
    if (!m_vis(t)) return 100;
    return 100 + (((t / HT) % VT) >> 1) * 4 + ((t % HT) >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, then release; afterwards edge n leaves counter state t=n
  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (lat_addr[k] !== 15'd100 || lat_hs[k] !== 1'b1 || lat_vs[k] !== 1'b1 ||
          lat_act[k] !== 1'b0 || lat_fs[k] !== 1'b0 || lat_color[k] !== 16'd0) begin
        errors++;
        $display("FAIL reset_state L=%0d got addr=%0d hs=%b vs=%b act=%b fs=%b col=%0d exp addr=100 hs=1 vs=1 act=0 fs=0 col=0",
                 k, lat_addr[k], lat_hs[k], lat_vs[k], lat_act[k], lat_fs[k], lat_color[k]);
      end
    end
    checks++;
    if (p_hs !== 1'b0 || p_vs !== 1'b0) begin
      errors++;
      $display("FAIL reset_pol got hs=%b vs=%b exp hs=0 vs=0", p_hs, p_vs);
    end
    checks++;
    if (w_addr !== 8'd250) begin
      errors++;
      $display("FAIL reset_wrap_addr got %0d exp 250", w_addr);
    end
  endtask

  task automatic test_timing();
    int hs_fall [2];
    int vs_fall [2];
    int nh, nv, first_act, fs_cnt, low_len;
    bit hs_log [0:200];
    bit prev_hs, prev_vs, prev_act;
    nh = 0; nv = 0; first_act = -1; fs_cnt = 0; low_len = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_act = 1'b0;
    apply_reset();
    for (int n = 1; n <= 200; n++) begin
      int  t;
      bit  e_act, e_fs;
      bit  e_hs, e_vs;
      step();
      t     = n - 3;
      e_act = (t >= 0) && m_vis(t);
      e_fs  = (t >= 0) && m_fs(t);
      e_hs  = !((t >= 0) && m_hs(t));
      e_vs  = !((t >= 0) && m_vs(t));
      checks++;
      if (lat_act[1] !== e_act || lat_fs[1] !== e_fs || lat_hs[1] !== e_hs || lat_vs[1] !== e_vs) begin
        errors++;
        $display("FAIL timing n=%0d got act=%b fs=%b hs=%b vs=%b exp act=%b fs=%b hs=%b vs=%b",
                 n, lat_act[1], lat_fs[1], lat_hs[1], lat_vs[1], e_act, e_fs, e_hs, e_vs);
      end
      hs_log[n] = lat_hs[1];
      if (prev_hs && !lat_hs[1] && nh < 2) begin hs_fall[nh] = n; nh++; end
      if (prev_vs && !lat_vs[1] && nv < 2) begin vs_fall[nv] = n; nv++; end
      if (!prev_act && lat_act[1] && first_act < 0) first_act = n;
      if (lat_fs[1] && n <= 196) fs_cnt++;
      prev_hs = lat_hs[1]; prev_vs = lat_vs[1]; prev_act = lat_act[1];
    end
    checks++;
    if (nh != 2 || hs_fall[1] - hs_fall[0] != 14) begin
      errors++;
      $display("FAIL h_total got falls=%0d period=%0d exp falls=2 period=14", nh, (nh == 2) ? hs_fall[1] - hs_fall[0] : -1);
    end
    checks++;
    if (nv != 2 || vs_fall[1] - vs_fall[0] != 98) begin
      errors++;
      $display("FAIL v_total got falls=%0d period=%0d exp falls=2 period=98", nv, (nv == 2) ? vs_fall[1] - vs_fall[0] : -1);
    end
    if (nh >= 1) begin
      for (int n = hs_fall[0]; n < hs_fall[0] + 14 && n <= 200; n++) if (!hs_log[n]) low_len++;
    end
    checks++;
    if (low_len != 3) begin
      errors++;
      $display("FAIL hsync_width got %0d exp 3", low_len);
    end
    checks++;
    if (nh < 1 || first_act != 3 || hs_fall[0] - first_act != 10) begin
      errors++;
      $display("FAIL hsync_offset got first_act=%0d fall=%0d exp first_act=3 fall=13", first_act, (nh >= 1) ? hs_fall[0] : -1);
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL framestart_count got %0d exp 2", fs_cnt);
    end
  endtask

  task automatic test_address_line2();
    int exp_tab [14] = '{104, 104, 105, 105, 106, 106, 107, 107, 100, 100, 100, 100, 100, 100};
    apply_reset();
    for (int n = 1; n <= 28; n++) step();
    for (int h = 0; h < 14; h++) begin
      step();
      checks++;
      if (int'(lat_addr[1]) != exp_tab[h]) begin
        errors++;
        $display("FAIL addr_line2 h=%0d got %0d exp %0d", h, lat_addr[1], exp_tab[h]);
      end
    end
  endtask

  task automatic test_latency_sweep();
    int act_cnt [5];
    for (int k = 0; k < 5; k++) act_cnt[k] = 0;
    apply_reset();
    for (int n = 1; n <= 120; n++) begin
      step();
      for (int k = 0; k < 5; k++) begin
        int t;
        bit e_act;
        int e_col;
        t     = n - k - 2;
        e_act = (t >= 0) && m_vis(t);
        e_col = e_act ? m_addr(t) : 0;
        checks++;
        if (lat_act[k] !== e_act || int'(lat_color[k]) != e_col) begin
          errors++;
          $display("FAIL latency L=%0d n=%0d got act=%b col=%0d exp act=%b col=%0d",
                   k, n, lat_act[k], lat_color[k], e_act, e_col);
        end
        if (lat_act[k] && t >= 0 && t < FRAME) act_cnt[k]++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (act_cnt[k] != 32) begin
        errors++;
        $display("FAIL active_span L=%0d got %0d exp 32", k, act_cnt[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    for (int n = 1; n <= 33; n++) step();
    checks++;
    if (lat_addr[1] !== 15'd106) begin
      errors++;
      $display("FAIL midframe_pos got addr=%0d exp 106", lat_addr[1]);
    end
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (lat_hs[k] !== 1'b1 || lat_vs[k] !== 1'b1 || lat_color[k] !== 16'd0 ||
            lat_addr[k] !== 15'd100 || lat_act[k] !== 1'b0) begin
          errors++;
          $display("FAIL midframe_reset L=%0d cyc=%0d got hs=%b vs=%b col=%0d addr=%0d act=%b exp hs=1 vs=1 col=0 addr=100 act=0",
                   k, i, lat_hs[k], lat_vs[k], lat_color[k], lat_addr[k], lat_act[k]);
        end
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (lat_fs[k] !== (n == k + 2)) begin
          errors++;
          $display("FAIL framestart_after_reset L=%0d n=%0d got %b exp %b", k, n, lat_fs[k], (n == k + 2));
        end
      end
    end
  endtask

  task automatic test_sync_pol();
    int fs_cnt;
    fs_cnt = 0;
    apply_reset();
    for (int n = 1; n <= 200; n++) begin
      int t;
      bit e_act, e_fs, e_hs, e_vs;
      step();
      t     = n - 3;
      e_act = (t >= 0) && m_vis(t);
      e_fs  = (t >= 0) && m_fs(t);
      e_hs  = (t >= 0) && m_hs(t);
      e_vs  = (t >= 0) && m_vs(t);
      checks++;
      if (p_hs !== e_hs || p_vs !== e_vs || p_act !== e_act || p_fs !== e_fs ||
          p_color !== (e_act ? 16'h1234 : 16'h0000)) begin
        errors++;
        $display("FAIL sync_pol n=%0d got hs=%b vs=%b act=%b fs=%b col=%h exp hs=%b vs=%b act=%b fs=%b",
                 n, p_hs, p_vs, p_act, p_fs, p_color, e_hs, e_vs, e_act, e_fs);
      end
      if (p_fs && p_act && n <= 196) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 2) begin
      errors++;
      $display("FAIL pol_framestart_count got %0d exp 2", fs_cnt);
    end
  endtask

  task automatic test_addr_wrap();
    apply_reset();
    for (int n = 1; n <= 16; n++) begin
      int e;
      step();
      case (n)
        6:       e = 255;
        7:       e = 0;
        8:       e = 1;
        9:       e = 250;
        15:      e = 2;
        default: e = -1;
      endcase
      if (e >= 0) begin
        checks++;
        if (int'(w_addr) != e) begin
          errors++;
          $display("FAIL addr_wrap n=%0d got %0d exp %0d", n, w_addr, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_address_line2();
    test_latency_sweep();
    test_reset_midframe();
    test_sync_pol();
    test_addr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
